// File: rtl/cps3_out_timing_gen_pkg.sv
// Shared output-timing defaults (720p), line-buffer depth, sync polarity and window helper.
package cps3_out_timing_gen_pkg;

  localparam int unsigned DEF_H_TOTAL          = 1650;
  localparam int unsigned DEF_H_SYNCLEN        = 40;
  localparam int unsigned DEF_H_BACKPORCH      = 220;
  localparam int unsigned DEF_H_ACTIVE         = 1280;
  localparam int unsigned DEF_V_TOTAL          = 750;
  localparam int unsigned DEF_V_SYNCLEN        = 5;
  localparam int unsigned DEF_V_BACKPORCH      = 20;
  localparam int unsigned DEF_V_ACTIVE         = 720;
  localparam int unsigned DEF_H_SCALE          = 3;
  localparam int unsigned DEF_V_SCALE          = 3;
  localparam int unsigned DEF_H_SRC_ACTIVE     = 384;
  localparam int unsigned DEF_V_SRC_ACTIVE     = 224;
  localparam int unsigned DEF_H_IMG_OFFSET     = 64;
  localparam int unsigned DEF_V_IMG_OFFSET     = 24;
  localparam int unsigned DEF_NUM_LINE_BUFFERS = 40;
  localparam int unsigned DEF_V_LOCK_LINE      = 0;

  localparam logic SYNC_ACTIVE_LVL = 1'b0;

  function automatic logic in_win(input logic [10:0] v, input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/cps3_out_timing_gen_sync_2ff.sv
// Two-flop synchronizer for an asynchronous active-low level; idles high out of reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/cps3_out_timing_gen.sv
// CPS3 output-side raster timing: counters, replication phases, sync/DE decode and
// frame lock of the output raster to the source VSYNC.
module cps3_out_timing_gen
  import cps3_out_timing_gen_pkg::*;
#(
  parameter int unsigned H_TOTAL          = DEF_H_TOTAL,
  parameter int unsigned H_SYNCLEN        = DEF_H_SYNCLEN,
  parameter int unsigned H_BACKPORCH      = DEF_H_BACKPORCH,
  parameter int unsigned H_ACTIVE         = DEF_H_ACTIVE,
  parameter int unsigned V_TOTAL          = DEF_V_TOTAL,
  parameter int unsigned V_SYNCLEN        = DEF_V_SYNCLEN,
  parameter int unsigned V_BACKPORCH      = DEF_V_BACKPORCH,
  parameter int unsigned V_ACTIVE         = DEF_V_ACTIVE,
  parameter int unsigned H_SCALE          = DEF_H_SCALE,
  parameter int unsigned V_SCALE          = DEF_V_SCALE,
  parameter int unsigned H_SRC_ACTIVE     = DEF_H_SRC_ACTIVE,
  parameter int unsigned V_SRC_ACTIVE     = DEF_V_SRC_ACTIVE,
  parameter int unsigned H_IMG_OFFSET     = DEF_H_IMG_OFFSET,
  parameter int unsigned V_IMG_OFFSET     = DEF_V_IMG_OFFSET,
  parameter int unsigned NUM_LINE_BUFFERS = DEF_NUM_LINE_BUFFERS,
  parameter int unsigned V_LOCK_LINE      = DEF_V_LOCK_LINE
) (
  input  logic        PCLK_ext,
  input  logic        reset_n,
  input  logic        VSYNC_in,
  input  logic        lock_en,
  output logic [10:0] hcnt_ext,
  output logic [10:0] vcnt_ext,
  output logic [8:0]  hcnt_ext_lbuf,
  output logic [5:0]  vcnt_ext_lbuf,
  output logic [2:0]  hctr_ext,
  output logic [2:0]  vctr_ext,
  output logic        HSYNC_ext,
  output logic        VSYNC_ext,
  output logic        DE_ext,
  output logic        mask_ext,
  output logic        locked
);

  localparam logic [10:0] C_HT_M1  = 11'(H_TOTAL - 1);
  localparam logic [10:0] C_VT_M1  = 11'(V_TOTAL - 1);
  localparam logic [10:0] C_HSYNC  = 11'(H_SYNCLEN);
  localparam logic [10:0] C_VSYNC  = 11'(V_SYNCLEN);
  localparam logic [10:0] C_HA0    = 11'(H_SYNCLEN + H_BACKPORCH);
  localparam logic [10:0] C_HA1    = 11'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
  localparam logic [10:0] C_VA0    = 11'(V_SYNCLEN + V_BACKPORCH);
  localparam logic [10:0] C_VA1    = 11'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
  localparam logic [10:0] C_HIMG0  = 11'(H_SYNCLEN + H_BACKPORCH + H_IMG_OFFSET);
  localparam logic [10:0] C_HIMG1  = 11'(H_SYNCLEN + H_BACKPORCH + H_IMG_OFFSET + H_SRC_ACTIVE * H_SCALE);
  localparam logic [10:0] C_VIMG0  = 11'(V_SYNCLEN + V_BACKPORCH + V_IMG_OFFSET);
  localparam logic [10:0] C_VIMG1  = 11'(V_SYNCLEN + V_BACKPORCH + V_IMG_OFFSET + V_SRC_ACTIVE * V_SCALE);
  localparam logic [10:0] C_VLOCK  = 11'(V_LOCK_LINE);
  localparam logic [2:0]  C_HS_M1  = 3'(H_SCALE - 1);
  localparam logic [2:0]  C_VS_M1  = 3'(V_SCALE - 1);
  localparam logic [5:0]  C_NLB_M1 = 6'(NUM_LINE_BUFFERS - 1);

  logic [10:0] r_hcnt, r_vcnt;
  logic [8:0]  r_hlbuf;
  logic [5:0]  r_vlbuf;
  logic [2:0]  r_hctr, r_vctr;
  logic        r_hsync, r_vsync, r_de, r_mask;
  logic        r_vs_prev, r_pending, r_locked;

  logic        w_vs_sync, w_fall, w_hwrap, w_lock_ld;
  logic [10:0] w_hcnt_nxt, w_vcnt_nat, w_vcnt_nxt;
  logic [8:0]  w_hlbuf_nxt;
  logic [5:0]  w_vlbuf_nxt;
  logic [2:0]  w_hctr_nxt, w_vctr_nxt;
  logic        w_act, w_img;

  sync_2ff u_vs_sync (
    .i_clk   (PCLK_ext),
    .i_rst_n (reset_n),
    .i_d     (VSYNC_in),
    .o_q     (w_vs_sync)
  );

  assign w_fall     = r_vs_prev & ~w_vs_sync;
  assign w_hwrap    = (r_hcnt == C_HT_M1);
  assign w_hcnt_nxt = w_hwrap ? '0 : r_hcnt + 11'd1;
  assign w_vcnt_nat = (r_vcnt == C_VT_M1) ? '0 : r_vcnt + 11'd1;
  assign w_lock_ld  = w_hwrap & r_pending & lock_en;

  // Replication state is computed against the *next* counter values so every
  // stage-0 register describes the same raster position in the same cycle.
  always_comb begin
    w_vcnt_nxt  = r_vcnt;
    w_hctr_nxt  = '0;
    w_hlbuf_nxt = '0;
    w_vctr_nxt  = r_vctr;
    w_vlbuf_nxt = r_vlbuf;
    if (w_hwrap) w_vcnt_nxt = w_lock_ld ? C_VLOCK : w_vcnt_nat;

    if (in_win(w_hcnt_nxt, C_HIMG0, C_HIMG1) && in_win(r_vcnt, C_VIMG0, C_VIMG1)) begin
      if (w_hcnt_nxt == C_HIMG0) begin
        w_hctr_nxt  = '0;
        w_hlbuf_nxt = '0;
      end else if (r_hctr == C_HS_M1) begin
        w_hctr_nxt  = '0;
        w_hlbuf_nxt = r_hlbuf + 9'd1;
      end else begin
        w_hctr_nxt  = r_hctr + 3'd1;
        w_hlbuf_nxt = r_hlbuf;
      end
    end

    if (w_hwrap) begin
      if (w_vcnt_nxt <= C_VIMG0) begin
        w_vctr_nxt  = '0;
        w_vlbuf_nxt = '0;
      end else if (w_vcnt_nxt < C_VIMG1) begin
        if (r_vctr == C_VS_M1) begin
          w_vctr_nxt  = '0;
          w_vlbuf_nxt = (r_vlbuf == C_NLB_M1) ? '0 : r_vlbuf + 6'd1;
        end else begin
          w_vctr_nxt  = r_vctr + 3'd1;
        end
      end
    end
  end

  assign w_act = in_win(r_hcnt, C_HA0, C_HA1) & in_win(r_vcnt, C_VA0, C_VA1);
  assign w_img = in_win(r_hcnt, C_HIMG0, C_HIMG1) & in_win(r_vcnt, C_VIMG0, C_VIMG1);

  always_ff @(posedge PCLK_ext or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_hlbuf   <= '0;
      r_vlbuf   <= '0;
      r_hctr    <= '0;
      r_vctr    <= '0;
      r_hsync   <= ~SYNC_ACTIVE_LVL;
      r_vsync   <= ~SYNC_ACTIVE_LVL;
      r_de      <= 1'b0;
      r_mask    <= 1'b0;
      r_vs_prev <= 1'b1;
      r_pending <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_hcnt    <= w_hcnt_nxt;
      r_vcnt    <= w_vcnt_nxt;
      r_hlbuf   <= w_hlbuf_nxt;
      r_vlbuf   <= w_vlbuf_nxt;
      r_hctr    <= w_hctr_nxt;
      r_vctr    <= w_vctr_nxt;
      r_hsync   <= (r_hcnt < C_HSYNC) ? SYNC_ACTIVE_LVL : ~SYNC_ACTIVE_LVL;
      r_vsync   <= (r_vcnt < C_VSYNC) ? SYNC_ACTIVE_LVL : ~SYNC_ACTIVE_LVL;
      r_de      <= w_act;
      r_mask    <= w_act & ~w_img;
      r_vs_prev <= w_vs_sync;
      // An edge coinciding with the consuming wrap re-arms for the following wrap.
      r_pending <= lock_en & (w_fall | (r_pending & ~w_hwrap));
      if (!lock_en)       r_locked <= 1'b0;
      else if (w_lock_ld) r_locked <= (w_vcnt_nat == C_VLOCK);
    end
  end

  assign hcnt_ext      = r_hcnt;
  assign vcnt_ext      = r_vcnt;
  assign hcnt_ext_lbuf = r_hlbuf;
  assign vcnt_ext_lbuf = r_vlbuf;
  assign hctr_ext      = r_hctr;
  assign vctr_ext      = r_vctr;
  assign HSYNC_ext     = r_hsync;
  assign VSYNC_ext     = r_vsync;
  assign DE_ext        = r_de;
  assign mask_ext      = r_mask;
  assign locked        = r_locked;

endmodule
